// File: rtl/axis_stream_arbiter.sv
// Round-robin, packet-locked AXI-Stream arbiter: NUM_SRC byte sources share one
// registered output beat stage; a grant is held until last or the MAX_BEATS limit.
module axis_stream_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NUM_SRC   = 4,
  parameter int MAX_BEATS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*WIDTH-1:0] s_axis_data,
  input  logic [NUM_SRC-1:0]       s_axis_valid,
  input  logic [NUM_SRC-1:0]       s_axis_last,
  output logic [NUM_SRC-1:0]       s_axis_ready,
  output logic [WIDTH-1:0]         m_axis_data,
  output logic                     m_axis_valid,
  output logic                     m_axis_last,
  input  logic                     m_axis_ready,
  output logic [NUM_SRC-1:0]       grant,
  output logic                     busy,
  output logic                     trunc
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           grant_idx_q, grant_idx_d;
  logic [PW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]           beat_cnt_q, beat_cnt_d;
  logic [NUM_SRC-1:0]      grant_q, grant_d;
  logic [WIDTH-1:0]        m_data_q, m_data_d;
  logic                    m_valid_q, m_valid_d;
  logic                    m_last_q, m_last_d;
  logic                    trunc_q, trunc_d;

  logic [NUM_SRC-1:0][WIDTH-1:0] src_data;
  logic                          out_free;
  logic                          accept;
  logic                          at_limit;
  logic                          found;
  logic [PW-1:0]                 winner;

  assign src_data = s_axis_data;
  assign out_free = !m_valid_q || m_axis_ready;
  assign at_limit = (beat_cnt_q == CW'(MAX_BEATS - 1));

  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    rr_ptr_d     = rr_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    grant_d      = grant_q;
    m_data_d     = m_data_q;
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    trunc_d      = 1'b0;
    s_axis_ready = '0;
    accept       = 1'b0;
    found        = 1'b0;
    winner       = '0;

    unique case (state_q)
      IDLE: begin
        // Scan from rr_ptr upward so the last-served source ends up lowest priority.
        for (int k = 0; k < NUM_SRC; k++) begin
          int idx;
          idx = (int'(rr_ptr_q) + k) % NUM_SRC;
          if (!found && s_axis_valid[idx]) begin
            found  = 1'b1;
            winner = PW'(idx);
          end
        end
        if (found) begin
          grant_idx_d = winner;
          grant_d     = NUM_SRC'(1) << winner;
          beat_cnt_d  = '0;
          state_d     = XFER;
        end
      end
      XFER: begin
        s_axis_ready[grant_idx_q] = out_free;
        accept = s_axis_valid[grant_idx_q] && out_free;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      m_data_d   = src_data[grant_idx_q];
      m_valid_d  = 1'b1;
      m_last_d   = s_axis_last[grant_idx_q] || at_limit;
      beat_cnt_d = beat_cnt_q + 1'b1;
      if (m_last_d) begin
        state_d  = IDLE;
        grant_d  = '0;
        rr_ptr_d = (int'(grant_idx_q) == NUM_SRC - 1) ? '0 : grant_idx_q + 1'b1;
        trunc_d  = !s_axis_last[grant_idx_q];
      end
    end else if (m_valid_q && m_axis_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      grant_q     <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      trunc_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      grant_q     <= grant_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      trunc_q     <= trunc_d;
    end
  end

  assign m_axis_data  = m_data_q;
  assign m_axis_valid = m_valid_q;
  assign m_axis_last  = m_last_q;
  assign grant        = grant_q;
  assign busy         = (state_q == XFER);
  assign trunc        = trunc_q;

endmodule

// File: tb/tb_axis_stream_arbiter.sv
// Scoreboard bench for axis_stream_arbiter: per-source beat queues feed the DUT,
// expected output beats are queued with the stimulus and compared on handshake.
module tb_axis_stream_arbiter;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int MB = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [N*W-1:0]   s_axis_data;
  logic [N-1:0]     s_axis_valid;
  logic [N-1:0]     s_axis_last;
  logic [N-1:0]     s_axis_ready;
  logic [W-1:0]     m_axis_data;
  logic             m_axis_valid;
  logic             m_axis_last;
  logic             m_axis_ready;
  logic [N-1:0]     grant;
  logic             busy;
  logic             trunc;

  always #5 clk = ~clk;

  axis_stream_arbiter #(.WIDTH(W), .NUM_SRC(N), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst(rst),
    .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid),
    .s_axis_last(s_axis_last), .s_axis_ready(s_axis_ready),
    .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid),
    .m_axis_last(m_axis_last), .m_axis_ready(m_axis_ready),
    .grant(grant), .busy(busy), .trunc(trunc)
  );

  typedef struct packed {logic last; logic [W-1:0] data;} beat_t;

  beat_t src_q[N][$];
  beat_t exp_q[$];
  bit    rdy_q[$];
  int    checks = 0, failures = 0;
  int    tb_beats = 0, trunc_cnt = 0, n_steps;
  bit    end_flag = 0, prev_stall = 0;
  beat_t prev_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_src(input int s, input logic [W-1:0] d, input logic l);
    beat_t b;
    b.data = d; b.last = l;
    src_q[s].push_back(b);
  endtask

  task automatic push_exp(input logic [W-1:0] d, input logic l);
    beat_t b;
    b.data = d; b.last = l;
    exp_q.push_back(b);
  endtask

  // One clock: drive at negedge, sample 1ns later, commit handshakes that the
  // coming rising edge will take.
  task automatic step();
    beat_t e;
    @(negedge clk);
    m_axis_ready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        s_axis_valid[i]       = 1'b1;
        s_axis_data[i*W +: W] = src_q[i][0].data;
        s_axis_last[i]        = src_q[i][0].last;
      end else begin
        s_axis_valid[i]       = 1'b0;
        s_axis_data[i*W +: W] = '0;
        s_axis_last[i]        = 1'b0;
      end
    end
    #1;
    if (end_flag) chk("gap_idle_ready", 32'(s_axis_ready), 32'h0);
    end_flag = 0;
    chk("ready_onehot", 32'($countones(s_axis_ready) <= 1), 32'h1);
    if (trunc) trunc_cnt++;
    if (prev_stall && m_axis_valid) chk("stall_hold", 32'({m_axis_last, m_axis_data}), 32'(prev_out));
    prev_stall = m_axis_valid && !m_axis_ready;
    prev_out   = {m_axis_last, m_axis_data};
    if (prev_stall) chk("stall_sready", 32'(s_axis_ready), 32'h0);
    if (m_axis_valid && m_axis_ready) begin
      if (exp_q.size() == 0) chk("exp_q_nonempty", 32'(exp_q.size()), 32'h1);
      else begin
        e = exp_q.pop_front();
        chk("out_beat", 32'({m_axis_last, m_axis_data}), 32'(e));
      end
    end
    for (int i = 0; i < N; i++) begin
      if (s_axis_valid[i] && s_axis_ready[i]) begin
        chk("grant_match", 32'(grant), 32'(1 << i));
        tb_beats++;
        if (src_q[i][0].last || tb_beats == MB) begin
          end_flag = 1;
          tb_beats = 0;
        end
        void'(src_q[i].pop_front());
      end
    end
  endtask

  task automatic drain(input int budget, output int n);
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    m_axis_ready = 1'b1;
    s_axis_valid = '0;
    s_axis_last  = '0;
    s_axis_data  = '0;
    #12;
    chk("rst_m_valid", 32'(m_axis_valid), 32'h0);
    chk("rst_m_data",  32'(m_axis_data),  32'h0);
    chk("rst_m_last",  32'(m_axis_last),  32'h0);
    chk("rst_grant",   32'(grant),        32'h0);
    chk("rst_busy",    32'(busy),         32'h0);
    chk("rst_trunc",   32'(trunc),        32'h0);
    chk("rst_sready",  32'(s_axis_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single 3-byte packet from source 0
    push_src(0, 8'h48, 0); push_src(0, 8'h49, 0); push_src(0, 8'h0A, 1);
    push_exp(8'h48, 0);    push_exp(8'h49, 0);    push_exp(8'h0A, 1);
    step();
    chk("t1_idle_sready", 32'(s_axis_ready), 32'h0);
    drain(20, n_steps);
    chk("t1_latency", 32'(n_steps), 32'd4);
    chk("t1_grant_after", 32'(grant), 32'h0);
    chk("t1_busy_after",  32'(busy),  32'h0);

    // rr_ptr is now 1: sources 0 and 3 request, 3 must win first
    push_src(0, 8'h01, 0); push_src(0, 8'h02, 1);
    push_src(3, 8'h31, 0); push_src(3, 8'h32, 1);
    push_exp(8'h31, 0); push_exp(8'h32, 1); push_exp(8'h01, 0); push_exp(8'h02, 1);
    drain(40, n_steps);

    // Backpressure: ready 1,0,0,1 across a 4-beat packet
    for (int b = 1; b <= 4; b++) begin
      push_src(1, 8'(8'h10 + b), b == 4);
      push_exp(8'(8'h10 + b), b == 4);
    end
    rdy_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    drain(40, n_steps);

    // Runaway packet: 20 beats, forced last at beat 16
    trunc_cnt = 0;
    for (int b = 1; b <= 20; b++) begin
      push_src(2, 8'(8'h80 + b), b == 20);
      push_exp(8'(8'h80 + b), (b == 16) || (b == 20));
    end
    drain(100, n_steps);
    step();
    chk("t4_trunc_pulses", 32'(trunc_cnt), 32'd1);

    // Reset mid-packet
    for (int b = 1; b <= 5; b++) push_src(1, 8'(8'hA0 + b), b == 5);
    push_exp(8'hA1, 0);
    step(); step(); step();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_m_valid", 32'(m_axis_valid), 32'h0);
    chk("mid_rst_m_last",  32'(m_axis_last),  32'h0);
    chk("mid_rst_m_data",  32'(m_axis_data),  32'h0);
    chk("mid_rst_grant",   32'(grant),        32'h0);
    chk("mid_rst_busy",    32'(busy),         32'h0);
    chk("mid_rst_exp",     32'(exp_q.size()), 32'h0);
    for (int i = 0; i < N; i++) src_q[i].delete();
    s_axis_valid = '0;
    tb_beats = 0; end_flag = 0; prev_stall = 0;
    @(negedge clk);
    rst = 1'b0;

    // All four request at once after reset: order 0,1,2,3,0
    push_src(0, 8'h00, 0); push_src(0, 8'h01, 1);
    push_src(0, 8'h02, 0); push_src(0, 8'h03, 1);
    for (int s = 1; s < N; s++) begin
      push_src(s, 8'(s * 16), 0); push_src(s, 8'(s * 16 + 1), 1);
    end
    push_exp(8'h00, 0); push_exp(8'h01, 1);
    push_exp(8'h10, 0); push_exp(8'h11, 1);
    push_exp(8'h20, 0); push_exp(8'h21, 1);
    push_exp(8'h30, 0); push_exp(8'h31, 1);
    push_exp(8'h02, 0); push_exp(8'h03, 1);
    drain(80, n_steps);
    step();
    chk("end_grant", 32'(grant), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
